safe_code_fsm: RTL and testbench

Combination-entry controller for the timed electronic safe; sits directly downstream of the button debounce/edge-detect stage and consumes its single-cycle enter pulse. Collects NUM_DIGITS switch digits, compares them against a stored combination, and holds the safe unlocked for a fixed cycle count. While unlocked, the combination can be reprogrammed. An optional lockout follows repeated failures.

---
 rtl/safe_code_fsm.sv | 174 +++++++++++++++++
 tb/tb_safe_code_fsm.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/safe_code_fsm.sv
// Combination-entry controller: collects digits, checks against a stored code, opens for a fixed time.
// Optional repeated-failure lockout is compiled in when SAFE_LOCKOUT_EN is defined.
module safe_code_fsm #(
    parameter int DIGIT_W = 4,
    parameter int NUM_DIGITS = 4,
    parameter logic [DIGIT_W*NUM_DIGITS-1:0] DEFAULT_CODE = 16'h1234,
    parameter int OPEN_CYCLES = 8,
    parameter int LOCK_CYCLES = 16,
    parameter int MAX_FAILS = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              enter_p,
    input  logic [DIGIT_W-1:0]                digit,
    input  logic                              set_mode,
    output logic                              unlocked,
    output logic                              error,
    output logic                              locked_out,
    output logic [$clog2(NUM_DIGITS+1)-1:0]   digit_cnt,
    output logic [2:0]                        fsm_state
);
    localparam int CODE_W  = DIGIT_W * NUM_DIGITS;
    localparam int CNT_W   = $clog2(NUM_DIGITS + 1);
    localparam int TMAX    = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int TIMER_W = $clog2(TMAX);

    typedef enum logic [2:0] {
        S_LOCKED  = 3'd0,
        S_CHECK   = 3'd1,
        S_OPEN    = 3'd2,
        S_PROG    = 3'd3,
        S_LOCKOUT = 3'd4
    } state_t;

    state_t               state, state_n;
    logic [CODE_W-1:0]    combo, combo_n;
    logic [CODE_W-1:0]    entry, entry_n;
    logic [CODE_W-1:0]    shifted;
    logic [CNT_W-1:0]     cnt_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic                 unlocked_n, error_n;
    logic                 last_digit;

`ifdef SAFE_LOCKOUT_EN
    localparam int FAIL_W = $clog2(MAX_FAILS + 1);
    logic [FAIL_W-1:0]    fail_cnt, fail_n;
    logic                 locked_q, locked_n;
    assign locked_out = locked_q;
`else
    localparam int UNUSED_MAX_FAILS = MAX_FAILS;
    assign locked_out = 1'b0;
`endif

    assign fsm_state  = state;
    assign shifted    = {entry[CODE_W-DIGIT_W-1:0], digit};
    assign last_digit = (digit_cnt == CNT_W'(NUM_DIGITS - 1));

    always_comb begin
        state_n = state;
        combo_n = combo;
        entry_n = entry;
        cnt_n   = digit_cnt;
        timer_n = timer;
        error_n = 1'b0;
`ifdef SAFE_LOCKOUT_EN
        fail_n  = fail_cnt;
`endif
        case (state)
            S_LOCKED: begin
                if (enter_p) begin
                    entry_n = shifted;
                    cnt_n   = digit_cnt + CNT_W'(1);
                    if (last_digit) state_n = S_CHECK;
                end
            end
            S_CHECK: begin
                entry_n = '0;
                cnt_n   = '0;
                if (entry == combo) begin
                    state_n = S_OPEN;
                    timer_n = TIMER_W'(OPEN_CYCLES - 1);
`ifdef SAFE_LOCKOUT_EN
                    fail_n  = '0;
`endif
                end else begin
                    error_n = 1'b1;
`ifdef SAFE_LOCKOUT_EN
                    fail_n  = fail_cnt + FAIL_W'(1);
                    if (fail_cnt == FAIL_W'(MAX_FAILS - 1)) begin
                        state_n = S_LOCKOUT;
                        timer_n = TIMER_W'(LOCK_CYCLES - 1);
                    end else begin
                        state_n = S_LOCKED;
                    end
`else
                    state_n = S_LOCKED;
`endif
                end
            end
            S_OPEN: begin
                // A pulse in the expiry cycle still takes effect, so enter_p is tested first.
                if (enter_p) begin
                    if (set_mode) begin
                        state_n = S_PROG;
                        entry_n = '0;
                        cnt_n   = '0;
                    end else begin
                        state_n = S_LOCKED;
                    end
                end else if (timer == '0) begin
                    state_n = S_LOCKED;
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
            S_PROG: begin
                if (enter_p) begin
                    entry_n = shifted;
                    cnt_n   = digit_cnt + CNT_W'(1);
                    if (last_digit) begin
                        combo_n = shifted;
                        entry_n = '0;
                        cnt_n   = '0;
                        state_n = S_OPEN;
                        timer_n = TIMER_W'(OPEN_CYCLES - 1);
                    end
                end
            end
`ifdef SAFE_LOCKOUT_EN
            S_LOCKOUT: begin
                if (timer == '0) begin
                    state_n = S_LOCKED;
                    fail_n  = '0;
                end else begin
                    timer_n = timer - TIMER_W'(1);
                end
            end
`endif
            default: state_n = S_LOCKED;
        endcase
        unlocked_n = (state_n == S_OPEN) || (state_n == S_PROG);
`ifdef SAFE_LOCKOUT_EN
        locked_n   = (state_n == S_LOCKOUT);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_LOCKED;
            combo     <= DEFAULT_CODE;
            entry     <= '0;
            digit_cnt <= '0;
            timer     <= '0;
            unlocked  <= 1'b0;
            error     <= 1'b0;
`ifdef SAFE_LOCKOUT_EN
            fail_cnt  <= '0;
            locked_q  <= 1'b0;
`endif
        end else begin
            state     <= state_n;
            combo     <= combo_n;
            entry     <= entry_n;
            digit_cnt <= cnt_n;
            timer     <= timer_n;
            unlocked  <= unlocked_n;
            error     <= error_n;
`ifdef SAFE_LOCKOUT_EN
            fail_cnt  <= fail_n;
            locked_q  <= locked_n;
`endif
        end
    end
endmodule

// File: tb/tb_safe_code_fsm.sv
// Directed bench for safe_code_fsm: expected attempt outcomes are queued by the driver
// and popped by a monitor whenever unlocked rises or error pulses.
module tb_safe_code_fsm;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enter_p = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       set_mode = 1'b0;
    logic       unlocked, error, locked_out;
    logic [2:0] digit_cnt;
    logic [2:0] fsm_state;

    int n_vec = 0;
    int n_bad = 0;
    logic [0:0] exp_q[$];
    logic prev_unl = 1'b0;
    logic prev_err = 1'b0;

    safe_code_fsm dut (
        .clk(clk), .rst(rst), .enter_p(enter_p), .digit(digit), .set_mode(set_mode),
        .unlocked(unlocked), .error(error), .locked_out(locked_out),
        .digit_cnt(digit_cnt), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Caller sits at a negedge; the pulse is sampled on the next posedge.
    task automatic press(input logic [3:0] d, input logic sm);
        enter_p  = 1'b1;
        digit    = d;
        set_mode = sm;
        @(negedge clk);
        enter_p  = 1'b0;
        set_mode = 1'b0;
    endtask

    task automatic enter_code(input logic [15:0] code, input bit push, input logic res);
        for (int i = 0; i < 4; i++) begin
            if (i == 3 && push) exp_q.push_back(res);
            press(code[15-4*i -: 4], 1'b0);
        end
    endtask

    // Called right after enter_code: state is CHECK now, result visible one edge later.
    task automatic expect_attempt(input string name, input logic res);
        check({name, "_cnt_in_check"}, digit_cnt, 4);
        @(negedge clk);
        check({name, "_unlocked"}, unlocked, res);
        check({name, "_error"}, error, !res);
        check({name, "_cnt_cleared"}, digit_cnt, 0);
    endtask

    task automatic measure_high(input string name, input int want, input bit use_lock);
        int cnt = 0;
        while (((use_lock ? locked_out : unlocked) === 1'b1) && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        check(name, cnt, want);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            prev_unl = 1'b0;
            prev_err = 1'b0;
        end else begin
            if ((unlocked && !prev_unl) || error) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_event: unlocked=%0d error=%0d with no attempt pending",
                             unlocked, error);
                end else begin
                    check("monitor_result", unlocked && !error, exp_q.pop_front());
                end
            end
            if (error) check("error_one_cycle", prev_err, 0);
            prev_unl = unlocked;
            prev_err = error;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_unlocked", unlocked, 0);
        check("rst_error", error, 0);
        check("rst_locked_out", locked_out, 0);
        check("rst_digit_cnt", digit_cnt, 0);
        rst = 1'b1;
        @(negedge clk);

        // Correct default code, open window length.
        enter_code(16'h1234, 1, 1'b1);
        expect_attempt("good", 1'b1);
        measure_high("open_len", 8, 0);
        check("good_cnt_after", digit_cnt, 0);

        // Wrong code.
        enter_code(16'h1235, 1, 1'b0);
        expect_attempt("bad", 1'b0);
        @(negedge clk);
        check("bad_error_gone", error, 0);
        check("bad_still_locked", unlocked, 0);

        // Asynchronous reset in the middle of an entry.
        press(4'd1, 1'b0);
        press(4'd2, 1'b0);
        check("mid_cnt", digit_cnt, 2);
        #2 rst = 1'b0;
        #1 check("async_rst_cnt", digit_cnt, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        enter_code(16'h1234, 1, 1'b1);
        expect_attempt("after_rst", 1'b1);
        measure_high("after_rst_open", 8, 0);

        // Reprogram to 9876.
        enter_code(16'h1234, 1, 1'b1);
        expect_attempt("open_for_prog", 1'b1);
        press(4'hF, 1'b1);
        check("prog_cnt_start", digit_cnt, 0);
        check("prog_unlocked", unlocked, 1);
        press(4'd9, 1'b0);
        press(4'd8, 1'b0);
        check("prog_cnt_mid", digit_cnt, 2);
        press(4'd7, 1'b0);
        press(4'd6, 1'b0);
        check("prog_done_cnt", digit_cnt, 0);
        check("prog_done_unlocked", unlocked, 1);
        press(4'd0, 1'b0);
        check("relock", unlocked, 0);
        enter_code(16'h1234, 1, 1'b0);
        expect_attempt("old_code", 1'b0);
        enter_code(16'h9876, 1, 1'b1);
        expect_attempt("new_code", 1'b1);
        measure_high("new_code_open", 8, 0);

        // Reset while open reverts the combination.
        enter_code(16'h9876, 1, 1'b1);
        expect_attempt("new_code_again", 1'b1);
        #2 rst = 1'b0;
        #1 check("async_rst_unlocked", unlocked, 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        enter_code(16'h9876, 1, 1'b0);
        expect_attempt("reverted_new", 1'b0);
        enter_code(16'h1234, 1, 1'b1);
        expect_attempt("reverted_default", 1'b1);
        measure_high("reverted_open", 8, 0);

`ifdef SAFE_LOCKOUT_EN
        enter_code(16'h0000, 1, 1'b0);
        expect_attempt("lock_try1", 1'b0);
        check("lock_try1_lo", locked_out, 0);
        enter_code(16'h1111, 1, 1'b0);
        expect_attempt("lock_try2", 1'b0);
        check("lock_try2_lo", locked_out, 0);
        enter_code(16'h2222, 1, 1'b0);
        expect_attempt("lock_try3", 1'b0);
        check("lockout_set", locked_out, 1);
        enter_code(16'h1234, 0, 1'b0);
        check("lockout_ignores_cnt", digit_cnt, 0);
        check("lockout_ignores_unl", unlocked, 0);
        measure_high("lockout_rest", 12, 1);
        enter_code(16'h1234, 1, 1'b1);
        expect_attempt("after_lockout", 1'b1);
        measure_high("after_lockout_open", 8, 0);
`else
        for (int i = 0; i < 5; i++) begin
            enter_code(16'h4321, 1, 1'b0);
            expect_attempt("nolock_bad", 1'b0);
            check("nolock_lo", locked_out, 0);
        end
        enter_code(16'h1234, 1, 1'b1);
        expect_attempt("nolock_good", 1'b1);
        measure_high("nolock_open", 8, 0);
`endif

        repeat (2) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
